bf_core: RTL and testbench
==========================

BF_CORE -- requirements
Module: bf_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8: tape cell width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16: tape pointer (sp) width in bits.
REQ-003 Parameter PC_WIDTH, default 16: program counter width in bits.
REQ-004 Parameter PROG_LEN, default 1024: number of valid program words, legal range 1..2**PC_WIDTH-1; pc==PROG_LEN means end of program.
REQ-005 Parameter DEPTH_WIDTH, default 8: loop-skip depth counter width in bits.
REQ-006 Ports SHALL be:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- pc  out  PC_WIDTH  program ROM address.
- pmem_data_read  in  3  opcode at pc, same-cycle (asynchronous ROM).
- sp  out  ADDR_WIDTH  tape address.
- tape_data_read  in  DATA_WIDTH  cell at sp, same-cycle.
- tape_we  out  1  tape write strobe, one cycle.
- tape_data_write  out  DATA_WIDTH  write data, valid with tape_we.
- in_valid  in  1  input byte available.
- in_data  in  DATA_WIDTH  input byte.
- in_ready  out  1  core waiting for input.
- out_valid  out  1  output byte pending.
- out_ready  in  1  sink accepts output.
- out_data  out  DATA_WIDTH  output byte.
- halted  out  1  core stopped, sticky until reset.
- error  out  1  abnormal halt, sticky until reset.

Function
REQ-007 Opcodes SHALL be 0 INC, 1 DEC, 2 INCSP, 3 DECSP, 4 '[', 5 ']', 6 COUT, 7 CIN.
REQ-008 States SHALL be FETCH, EXEC, SKIP_FWD, SKIP_BWD, WAIT_OUT, WAIT_IN, HALT; all outputs registered.
REQ-009 FETCH: if pc==PROG_LEN -> HALT with halted=1, error=0; else latch pmem_data_read as opcode -> EXEC.
REQ-010 EXEC INC/DEC: tape_we=1 next cycle, tape_data_write=tape_data_read+/-1 mod 2**DATA_WIDTH, pc+1, -> FETCH.
REQ-011 EXEC INCSP/DECSP: sp+/-1 mod 2**ADDR_WIDTH, pc+1, -> FETCH.
REQ-012 Simple instructions SHALL take exactly 2 cycles (FETCH+EXEC); a tape write issued in EXEC SHALL be visible to the next EXEC read.
REQ-013 EXEC '[': cell==0 -> depth=1, pc+1, SKIP_FWD; else pc+1, FETCH.
REQ-014 EXEC ']': cell!=0 -> depth=1, pc-1, SKIP_BWD; else pc+1, FETCH.
REQ-015 SKIP_FWD, one word per cycle at pc:
- '[' -> depth+1, pc+1.
- ']' with depth==1 -> pc+1, FETCH, so execution resumes after the matching ']'.
- ']' with depth>1 -> depth-1, pc+1.
- other opcodes -> pc+1.
REQ-016 SKIP_BWD, one word per cycle at pc:
- ']' -> depth+1, pc-1.
- '[' with depth==1 -> pc+1, FETCH, so execution resumes after the matching '['.
- '[' with depth>1 -> depth-1, pc-1.
- other opcodes -> pc-1.
REQ-017 Skip faults SHALL set HALT with halted=1, error=1:
- SKIP_FWD reaching pc==PROG_LEN.
- SKIP_BWD at pc==0 without a match.
- depth increment past 2**DEPTH_WIDTH-1.
REQ-018 EXEC COUT: out_valid=1, out_data=cell, -> WAIT_OUT; out_valid and out_data SHALL hold until a rising edge with out_valid&&out_ready, then out_valid=0, pc+1, FETCH.
REQ-019 EXEC CIN: in_ready=1 -> WAIT_IN; on an edge with in_valid&&in_ready: in_ready=0, tape_we=1, tape_data_write=in_data, pc+1, FETCH.
REQ-020 HALT SHALL be terminal: no pc/sp change, no tape_we, out_valid=0, in_ready=0.
REQ-021 tape_we SHALL be 0 in every cycle except the one after an INC/DEC EXEC or a CIN transfer; out_data and tape_data_write SHALL hold their last values otherwise.

Reset
REQ-022 reset_n low SHALL immediately force: pc=0, sp=0, tape_we=0, tape_data_write=0, out_valid=0, out_data=0, in_ready=0, halted=0, error=0, depth=0, state FETCH.
REQ-023 Reset asserted mid-operation (WAIT_OUT, WAIT_IN, skip) SHALL abandon the pending transfer; nothing is accepted on the deasserting edge.
REQ-024 The first FETCH SHALL occur on the first rising edge after reset_n deasserts.

Verification
REQ-025 "+++." with out_ready low 5 cycles -> out_valid=1, out_data=3 held stable 5 cycles; one transfer; then halted=1, error=0.
REQ-026 "[[+]+]." with tape zero -> no tape_we inside loops; out_data=0; halted=1.
REQ-027 "++[>+<-]>." -> out_data=2; tape[0]=0, tape[1]=2.
REQ-028 DATA_WIDTH=8, ADDR_WIDTH=4: "-<." from reset -> tape[15] read, tape[0]=255, sp=15, out_data=0.
REQ-029 ",." with in_valid raised 3 cycles late, in_data=0x41 -> in_ready held, tape[0]=0x41, out_data=0x41.
REQ-030 Fault and reset cases:
- "+]" -> halted=1, error=1.
- "[" with cell 0 -> halted=1, error=1.
- reset_n pulsed low during WAIT_OUT -> out_valid=0 at once, pc=0.

Source files
------------

// File: rtl/bf_core.sv
// Brainfuck interpreter core: fetch/execute FSM over an asynchronous program ROM and tape RAM,
// with ready/valid byte I/O and bracket matching by linear scan with a depth counter.
module bf_core #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned PROG_LEN    = 1024,
  parameter int unsigned DEPTH_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [2:0]            pmem_data_read,
  output logic [ADDR_WIDTH-1:0] sp,
  input  logic [DATA_WIDTH-1:0] tape_data_read,
  output logic                  tape_we,
  output logic [DATA_WIDTH-1:0] tape_data_write,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  halted,
  output logic                  error
);

  typedef enum logic [2:0] {
    StFetch, StExec, StSkipFwd, StSkipBwd, StWaitOut, StWaitIn, StHalt
  } state_e;

  typedef enum logic [2:0] {
    OpInc, OpDec, OpIncSp, OpDecSp, OpLoopBeg, OpLoopEnd, OpOut, OpIn
  } op_e;

  localparam logic [PC_WIDTH-1:0]    ProgEnd  = PC_WIDTH'(PROG_LEN);
  localparam logic [PC_WIDTH-1:0]    PcOne    = PC_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  SpOne    = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DataOne  = DATA_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0] DepthOne = DEPTH_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0] DepthMax = '1;

  state_e                  state_q;
  op_e                     op_q;
  op_e                     rom_op;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [ADDR_WIDTH-1:0]   sp_q;
  logic [DEPTH_WIDTH-1:0]  depth_q;
  logic                    tape_we_q, in_ready_q, out_valid_q, halted_q, error_q;
  logic [DATA_WIDTH-1:0]   tape_wdata_q, out_data_q;
  logic                    cell_zero;

  assign rom_op    = op_e'(pmem_data_read);
  assign cell_zero = (tape_data_read == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      op_q         <= OpInc;
      pc_q         <= '0;
      sp_q         <= '0;
      depth_q      <= '0;
      tape_we_q    <= 1'b0;
      tape_wdata_q <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      tape_we_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (pc_q == ProgEnd) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            op_q    <= rom_op;
            state_q <= StExec;
          end
        end
        StExec: begin
          unique case (op_q)
            OpInc, OpDec: begin
              tape_we_q    <= 1'b1;
              tape_wdata_q <= (op_q == OpInc) ? tape_data_read + DataOne
                                              : tape_data_read - DataOne;
              pc_q         <= pc_q + PcOne;
              state_q      <= StFetch;
            end
            OpIncSp, OpDecSp: begin
              sp_q    <= (op_q == OpIncSp) ? sp_q + SpOne : sp_q - SpOne;
              pc_q    <= pc_q + PcOne;
              state_q <= StFetch;
            end
            OpLoopBeg: begin
              pc_q <= pc_q + PcOne;
              if (cell_zero) begin
                depth_q <= DepthOne;
                state_q <= StSkipFwd;
              end else begin
                state_q <= StFetch;
              end
            end
            OpLoopEnd: begin
              if (cell_zero) begin
                pc_q    <= pc_q + PcOne;
                state_q <= StFetch;
              end else if (pc_q == '0) begin
                // ']' at address 0 can never have a matching '['
                state_q  <= StHalt;
                halted_q <= 1'b1;
                error_q  <= 1'b1;
              end else begin
                depth_q <= DepthOne;
                pc_q    <= pc_q - PcOne;
                state_q <= StSkipBwd;
              end
            end
            OpOut: begin
              out_valid_q <= 1'b1;
              out_data_q  <= tape_data_read;
              state_q     <= StWaitOut;
            end
            OpIn: begin
              in_ready_q <= 1'b1;
              state_q    <= StWaitIn;
            end
          endcase
        end
        StSkipFwd: begin
          if (pc_q == ProgEnd || (rom_op == OpLoopBeg && depth_q == DepthMax)) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            error_q  <= 1'b1;
          end else begin
            pc_q <= pc_q + PcOne;
            if (rom_op == OpLoopBeg) begin
              depth_q <= depth_q + DepthOne;
            end else if (rom_op == OpLoopEnd) begin
              if (depth_q == DepthOne) state_q <= StFetch;
              else                     depth_q <= depth_q - DepthOne;
            end
          end
        end
        StSkipBwd: begin
          if (rom_op == OpLoopBeg && depth_q == DepthOne) begin
            pc_q    <= pc_q + PcOne;
            state_q <= StFetch;
          end else if (pc_q == '0 || (rom_op == OpLoopEnd && depth_q == DepthMax)) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            error_q  <= 1'b1;
          end else begin
            pc_q <= pc_q - PcOne;
            if (rom_op == OpLoopEnd)      depth_q <= depth_q + DepthOne;
            else if (rom_op == OpLoopBeg) depth_q <= depth_q - DepthOne;
          end
        end
        StWaitOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_q + PcOne;
            state_q     <= StFetch;
          end
        end
        StWaitIn: begin
          if (in_valid) begin
            in_ready_q   <= 1'b0;
            tape_we_q    <= 1'b1;
            tape_wdata_q <= in_data;
            pc_q         <= pc_q + PcOne;
            state_q      <= StFetch;
          end
        end
        StHalt: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
        default: begin
          state_q  <= StHalt;
          halted_q <= 1'b1;
          error_q  <= 1'b1;
        end
      endcase
    end
  end

  assign pc              = pc_q;
  assign sp              = sp_q;
  assign tape_we         = tape_we_q;
  assign tape_data_write = tape_wdata_q;
  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign halted          = halted_q;
  assign error           = error_q;

endmodule

// File: tb/tb_bf_core.sv
// Directed bench for bf_core: table of whole programs run to halt, plus hand-written
// sequences for output backpressure, late input, and reset during a pending transfer.
module tb_bf_core;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 16;
  localparam int unsigned PL = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW-1:0] pc;
  logic [2:0]    pmem_data_read;
  logic [AW-1:0] sp;
  logic [DW-1:0] tape_data_read;
  logic          tape_we;
  logic [DW-1:0] tape_data_write;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          halted;
  logic          error;

  logic [2:0]    rom [PL];
  logic [DW-1:0] tape [16];
  logic          tape_clr = 1'b0;
  int            xfer_cnt = 0;
  int            we_cnt = 0;
  logic [DW-1:0] last_out = '0;
  int            checks = 0;
  int            failures = 0;

  bf_core #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_WIDTH(PW), .PROG_LEN(PL), .DEPTH_WIDTH(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .pmem_data_read(pmem_data_read),
    .sp(sp), .tape_data_read(tape_data_read), .tape_we(tape_we),
    .tape_data_write(tape_data_write), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .halted(halted), .error(error)
  );

  always #5 clock = ~clock;

  assign pmem_data_read = rom[pc[3:0]];
  assign tape_data_read = tape[sp];

  always @(posedge clock) begin
    if (tape_clr) begin
      for (int i = 0; i < 16; i++) tape[i] <= '0;
    end else if (tape_we) begin
      tape[sp] <= tape_data_write;
    end
    if (tape_we) we_cnt <= we_cnt + 1;
    if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      last_out <= out_data;
    end
  end

  typedef struct {
    string       prog;
    logic [7:0]  in_byte;
    bit          chk_out;
    logic [7:0]  exp_out;
    bit          exp_err;
    logic [7:0]  exp_t0;
    logic [7:0]  exp_t1;
  } vec_t;

  function automatic logic [2:0] op_of(input byte c);
    case (c)
      "+": return 3'd0;
      "-": return 3'd1;
      ">": return 3'd2;
      "<": return 3'd3;
      "[": return 3'd4;
      "]": return 3'd5;
      ".": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Unused ROM words are filled with alternating '>' '<', which never touch the tape.
  task automatic load_prog(input string s);
    for (int i = 0; i < int'(PL); i++) begin
      if (i < s.len()) rom[i] = op_of(s[i]);
      else             rom[i] = ((i - s.len()) % 2 == 0) ? 3'd2 : 3'd3;
    end
  endtask

  task automatic start();
    reset_n  = 1'b0;
    tape_clr = 1'b1;
    repeat (2) @(negedge clock);
    tape_clr = 1'b0;
    reset_n  = 1'b1;
  endtask

  task automatic run_to_halt(input string name);
    for (int n = 0; n < 3000 && !halted; n++) @(negedge clock);
    check({name, " halted"}, int'(halted), 1);
  endtask

  task automatic wait_out_valid(input string name);
    for (int n = 0; n < 500 && !out_valid; n++) @(negedge clock);
    check({name, " out_valid"}, int'(out_valid), 1);
  endtask

  vec_t vecs [9];
  int   we0, x0;

  initial begin
    vecs[0] = '{"+++.",       8'h00, 1, 8'd3,   0, 8'd3,   8'd0};
    vecs[1] = '{"[[+]+].",    8'h00, 1, 8'd0,   0, 8'd0,   8'd0};
    vecs[2] = '{"++[>+<-]>.", 8'h00, 1, 8'd2,   0, 8'd0,   8'd2};
    vecs[3] = '{"-<.",        8'h00, 1, 8'd0,   0, 8'd255, 8'd0};
    vecs[4] = '{",.",         8'h41, 1, 8'h41,  0, 8'h41,  8'd0};
    vecs[5] = '{"+]",         8'h00, 0, 8'd0,   1, 8'd1,   8'd0};
    vecs[6] = '{"[",          8'h00, 0, 8'd0,   1, 8'd0,   8'd0};
    vecs[7] = '{"+[-]-.",     8'h00, 1, 8'd255, 0, 8'd255, 8'd0};
    vecs[8] = '{"+[[-]]-.",   8'h00, 1, 8'd255, 0, 8'd255, 8'd0};

    // Reset values while reset is held
    load_prog("+++.");
    reset_n = 1'b0;
    #1;
    check("reset pc", int'(pc), 0);
    check("reset sp", int'(sp), 0);
    check("reset outs", int'({tape_we, out_valid, in_ready, halted, error}), 0);
    check("reset data", int'({out_data, tape_data_write}), 0);

    // Table-driven programs
    for (int v = 0; v < 9; v++) begin
      load_prog(vecs[v].prog);
      in_valid  = 1'b1;
      in_data   = vecs[v].in_byte;
      out_ready = 1'b1;
      start();
      we0 = we_cnt;
      x0  = xfer_cnt;
      run_to_halt(vecs[v].prog);
      check({vecs[v].prog, " error"}, int'(error), int'(vecs[v].exp_err));
      check({vecs[v].prog, " tape0"}, int'(tape[0]), int'(vecs[v].exp_t0));
      check({vecs[v].prog, " tape1"}, int'(tape[1]), int'(vecs[v].exp_t1));
      if (vecs[v].chk_out) begin
        check({vecs[v].prog, " out_data"}, int'(last_out), int'(vecs[v].exp_out));
        check({vecs[v].prog, " xfers"}, xfer_cnt - x0, 1);
      end
      if (v == 1) check("nested skip tape_we", we_cnt - we0, 0);
      check({vecs[v].prog, " no out in halt"}, int'(out_valid | in_ready), 0);
    end

    // Output held under backpressure
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load_prog("+++.");
    start();
    x0 = xfer_cnt;
    wait_out_valid("bp");
    for (int c = 0; c < 5; c++) begin
      check("bp hold valid", int'(out_valid), 1);
      check("bp hold data", int'(out_data), 3);
      check("bp hold pc", int'(pc), 3);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp valid drop", int'(out_valid), 0);
    check("bp one xfer", xfer_cnt - x0, 1);
    run_to_halt("bp");
    check("bp error", int'(error), 0);
    check("bp total xfer", xfer_cnt - x0, 1);

    // Input arriving late
    load_prog(",.");
    start();
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clock);
    check("in ready", int'(in_ready), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("in ready held", int'(in_ready), 1);
      check("in no write", int'(tape_we), 0);
    end
    in_data  = 8'h41;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("in ready drop", int'(in_ready), 0);
    check("in tape_we", int'(tape_we), 1);
    check("in wdata", int'(tape_data_write), 8'h41);
    run_to_halt("in");
    check("in tape0", int'(tape[0]), 8'h41);
    check("in out_data", int'(last_out), 8'h41);

    // Pointer wrap, then reset abandons the pending output
    out_ready = 1'b0;
    load_prog("-<.");
    start();
    wait_out_valid("wrap");
    check("wrap sp", int'(sp), 15);
    check("wrap out_data", int'(out_data), 0);
    check("wrap tape0", int'(tape[0]), 255);
    x0 = xfer_cnt;
    reset_n   = 1'b0;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst pc", int'(pc), 0);
    out_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst no xfer", xfer_cnt - x0, 0);
    check("rst first exec", int'(pc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
